// File: rtl/pacman_pkg.sv
// Shared maze-game definitions: direction codes, ghost motion FSM states and
// the on-screen coordinate type.
package pacman_pkg;

  typedef logic [9:0] coord_t;

  localparam logic [7:0] DIR_LEFT  = 8'h04;
  localparam logic [7:0] DIR_RIGHT = 8'h07;
  localparam logic [7:0] DIR_DOWN  = 8'h16;
  localparam logic [7:0] DIR_UP    = 8'h1A;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TRY_NEW = 2'd1,
    TRY_CUR = 2'd2
  } state_t;

endpackage

// File: rtl/dir_decode.sv
// Maps an 8-bit direction code to a unit step (screen coordinates, y grows
// downward) and flags whether the code is one of the four known directions.
module dir_decode
  import pacman_pkg::*;
(
  input  logic [7:0]        code,
  output logic signed [1:0] dx,
  output logic signed [1:0] dy,
  output logic              valid
);

  always_comb begin
    dx    = 2'sd0;
    dy    = 2'sd0;
    valid = 1'b0;
    case (code)
      DIR_LEFT:  begin dx = -2'sd1; valid = 1'b1; end
      DIR_RIGHT: begin dx =  2'sd1; valid = 1'b1; end
      DIR_DOWN:  begin dy =  2'sd1; valid = 1'b1; end
      DIR_UP:    begin dy = -2'sd1; valid = 1'b1; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/ghost_motion.sv
// Per-frame ghost mover: tries the requested direction, falls back to the
// current heading, and checks each candidate against bounds and a wall lookup.
module ghost_motion
  import pacman_pkg::*;
#(
  parameter coord_t     X_INIT = 10'd320,
  parameter coord_t     Y_INIT = 10'd240,
  parameter coord_t     X_MIN  = 10'd8,
  parameter coord_t     X_MAX  = 10'd631,
  parameter coord_t     Y_MIN  = 10'd8,
  parameter coord_t     Y_MAX  = 10'd471,
  parameter logic [3:0] STEP   = 4'd1
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic [7:0] dir_in,
  output logic       wall_req,
  output coord_t     wall_x,
  output coord_t     wall_y,
  input  logic       wall_ack,
  input  logic       wall_hit,
  output coord_t     ghost_x,
  output coord_t     ghost_y,
  output logic [7:0] heading,
  output logic       moving,
  output logic       overrun,
  output state_t     dbg_state
);

  // Handshake: wall_req is held with wall_x/wall_y stable until a cycle with
  // wall_ack=1, where wall_hit is sampled; wall_req then drops the next cycle.

  state_t     state_q, state_d;
  coord_t     x_q, x_d, y_q, y_d, cx_q, cx_d, cy_q, cy_d;
  logic [7:0] heading_q, heading_d, new_dir_q, new_dir_d;
  logic       moving_q, moving_d, req_q, req_d, oob_q, oob_d;
  logic       pend_q, pend_d, overrun_q, overrun_d;

  logic signed [1:0] in_dx, in_dy, hd_dx, hd_dy, sel_dx, sel_dy;
  logic              in_valid, hd_valid, use_new;
  logic [10:0]       nx, ny;
  logic              n_oob, resolved, hit;

  dir_decode u_in_dec (.code(dir_in),    .dx(in_dx), .dy(in_dy), .valid(in_valid));
  dir_decode u_hd_dec (.code(heading_q), .dx(hd_dx), .dy(hd_dy), .valid(hd_valid));

  assign use_new = (state_q == IDLE) && in_valid && (dir_in != heading_q);

  // 11-bit candidate: a step below zero wraps far above the max bound
  always_comb begin
    sel_dx = 2'sd0;
    sel_dy = 2'sd0;
    if (use_new) begin
      sel_dx = in_dx;
      sel_dy = in_dy;
    end else if (hd_valid) begin
      sel_dx = hd_dx;
      sel_dy = hd_dy;
    end
    nx = {1'b0, x_q};
    ny = {1'b0, y_q};
    if (sel_dx == 2'sd1)       nx = nx + {7'd0, STEP};
    else if (sel_dx == -2'sd1) nx = nx - {7'd0, STEP};
    if (sel_dy == 2'sd1)       ny = ny + {7'd0, STEP};
    else if (sel_dy == -2'sd1) ny = ny - {7'd0, STEP};
    n_oob = (nx < {1'b0, X_MIN}) || (nx > {1'b0, X_MAX}) ||
            (ny < {1'b0, Y_MIN}) || (ny > {1'b0, Y_MAX});
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    heading_d = heading_q;
    new_dir_d = new_dir_q;
    moving_d  = moving_q;
    req_d     = req_q;
    oob_d     = oob_q;
    pend_d    = pend_q;
    overrun_d = overrun_q | (frame_tick & (state_q != IDLE));
    resolved  = oob_q | (req_q & wall_ack);
    hit       = oob_q | wall_hit;
    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          state_d   = use_new ? TRY_NEW : TRY_CUR;
          new_dir_d = dir_in;
          cx_d      = nx[9:0];
          cy_d      = ny[9:0];
          oob_d     = n_oob;
          req_d     = !n_oob;
        end
      end
      TRY_NEW: begin
        if (resolved) begin
          req_d = 1'b0;
          if (!hit) begin
            heading_d = new_dir_q;
            x_d       = cx_q;
            y_d       = cy_q;
            moving_d  = 1'b1;
            oob_d     = 1'b0;
            state_d   = IDLE;
          end else begin
            // Fall back to the held heading; its request goes out one cycle later
            cx_d    = nx[9:0];
            cy_d    = ny[9:0];
            oob_d   = n_oob;
            pend_d  = !n_oob;
            state_d = TRY_CUR;
          end
        end
      end
      TRY_CUR: begin
        if (pend_q) begin
          req_d  = 1'b1;
          pend_d = 1'b0;
        end else if (resolved) begin
          req_d   = 1'b0;
          oob_d   = 1'b0;
          state_d = IDLE;
          if (!hit) begin
            x_d      = cx_q;
            y_d      = cy_q;
            moving_d = 1'b1;
          end else begin
            moving_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      x_q       <= X_INIT;
      y_q       <= Y_INIT;
      cx_q      <= '0;
      cy_q      <= '0;
      heading_q <= DIR_LEFT;
      new_dir_q <= DIR_LEFT;
      moving_q  <= 1'b0;
      req_q     <= 1'b0;
      oob_q     <= 1'b0;
      pend_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      heading_q <= heading_d;
      new_dir_q <= new_dir_d;
      moving_q  <= moving_d;
      req_q     <= req_d;
      oob_q     <= oob_d;
      pend_q    <= pend_d;
      overrun_q <= overrun_d;
    end
  end

  assign wall_req  = req_q;
  assign wall_x    = cx_q;
  assign wall_y    = cy_q;
  assign ghost_x   = x_q;
  assign ghost_y   = y_q;
  assign heading   = heading_q;
  assign moving    = moving_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ghost_motion.sv
// Bench for ghost_motion: a frame-level reference model predicts each wall
// request and each frame outcome; monitors compare them as the DUT produces them.
module tb_ghost_motion;
  import pacman_pkg::*;

  localparam int W = 29;  // {x[9:0], y[9:0], heading[7:0], moving}

  logic       Clk, Reset_n, frame_tick, wall_ack, wall_hit;
  logic       wall_req, moving, overrun;
  logic [7:0] dir_in, heading;
  logic [9:0] wall_x, wall_y, ghost_x, ghost_y;
  state_t     dbg_state;

  ghost_motion dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .dir_in(dir_in),
    .wall_req(wall_req), .wall_x(wall_x), .wall_y(wall_y),
    .wall_ack(wall_ack), .wall_hit(wall_hit),
    .ghost_x(ghost_x), .ghost_y(ghost_y), .heading(heading),
    .moving(moving), .overrun(overrun), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- shared state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [W-1:0] exp_q[$];
  logic [19:0] req_q[$];
  bit          blocked[int];
  bit          hash_walls = 1'b0;
  bit          spur_en = 1'b0;
  int          ack_lat = 0;
  bit          exp_overrun = 1'b0;
  int          mx, my;
  logic [7:0]  mhead;
  logic [7:0]  dir_tab[4] = '{8'h04, 8'h07, 8'h16, 8'h1A};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit wall_at(input int x, input int y);
    return blocked.exists(x * 1024 + y) || (hash_walls && ((x * 31 + y * 17) % 5 == 0));
  endfunction

  function automatic void dir_delta(input logic [7:0] d, output int dx, output int dy, output bit ok);
    dx = 0; dy = 0; ok = 1'b1;
    case (d)
      8'h04:   dx = -1;
      8'h07:   dx = 1;
      8'h16:   dy = 1;
      8'h1A:   dy = -1;
      default: ok = 1'b0;
    endcase
  endfunction

  // Frame-level reference: try requested direction (if new), then heading.
  task automatic model_frame(input logic [7:0] d);
    logic [7:0] tries[$];
    int dx, dy, nx, ny;
    bit ok, done;
    dir_delta(d, dx, dy, ok);
    if (ok && d != mhead) tries.push_back(d);
    tries.push_back(mhead);
    done = 1'b0;
    foreach (tries[i]) begin
      if (!done) begin
        dir_delta(tries[i], dx, dy, ok);
        nx = mx + dx;
        ny = my + dy;
        if (nx >= 8 && nx <= 631 && ny >= 8 && ny <= 471) begin
          req_q.push_back({nx[9:0], ny[9:0]});
          if (!wall_at(nx, ny)) begin
            mx = nx; my = ny; mhead = tries[i]; done = 1'b1;
          end
        end
      end
    end
    exp_q.push_back({mx[9:0], my[9:0], mhead, done});
  endtask

  task automatic model_reset();
    mx = 320; my = 240; mhead = 8'h04; exp_overrun = 1'b0;
    exp_q.delete();
    req_q.delete();
  endtask

  // ---------------- wall lookup responder ----------------
  initial begin : responder
    bit busy;
    int wait_n;
    busy = 1'b0; wait_n = 0;
    wall_ack = 1'b0; wall_hit = 1'b0;
    forever begin
      @(negedge Clk);
      wall_ack = 1'b0;
      wall_hit = 1'b0;
      if (!wall_req) begin
        busy = 1'b0;
        if (spur_en && $urandom_range(0, 7) == 0) begin
          wall_ack = 1'b1;
          wall_hit = 1'($urandom_range(0, 1));
        end
      end else begin
        if (!busy) begin
          busy = 1'b1;
          wait_n = ack_lat;
        end
        if (wait_n == 0) begin
          wall_ack = 1'b1;
          wall_hit = wall_at(int'(wall_x), int'(wall_y));
        end else begin
          wait_n--;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic        prev_req;
    state_t      prev_state;
    logic [19:0] held;
    logic [W-1:0] e;
    prev_req = 1'b0; prev_state = IDLE; held = '0;
    forever begin
      @(negedge Clk);
      if (!Reset_n) begin
        prev_req = 1'b0;
        prev_state = IDLE;
      end else begin
        if (wall_req && !prev_req) begin
          if (req_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_req: got (%0d,%0d) expected no request at %0t", wall_x, wall_y, $time);
          end else begin
            held = req_q.pop_front();
            check("wall_xy", 32'({wall_x, wall_y}), 32'(held));
          end
        end else if (wall_req) begin
          check("wall_xy_stable", 32'({wall_x, wall_y}), 32'(held));
        end
        if (dbg_state == IDLE && prev_state != IDLE) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_frame: got (%0d,%0d) expected no completion at %0t", ghost_x, ghost_y, $time);
          end else begin
            e = exp_q.pop_front();
            check("ghost_x", 32'(ghost_x), 32'(e[28:19]));
            check("ghost_y", 32'(ghost_y), 32'(e[18:9]));
            check("heading", 32'(heading), 32'(e[8:1]));
            check("moving",  32'(moving),  32'(e[0]));
            check("overrun", 32'(overrun), 32'(exp_overrun));
          end
        end
        prev_req = wall_req;
        prev_state = dbg_state;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_x"},       32'(ghost_x),   32'd320);
    check({tag, "_y"},       32'(ghost_y),   32'd240);
    check({tag, "_heading"}, 32'(heading),   32'h04);
    check({tag, "_moving"},  32'(moving),    32'd0);
    check({tag, "_req"},     32'(wall_req),  32'd0);
    check({tag, "_overrun"}, 32'(overrun),   32'd0);
    check({tag, "_state"},   32'(dbg_state), 32'(IDLE));
  endtask

  task automatic do_reset();
    Reset_n = 1'b0; frame_tick = 1'b0; dir_in = 8'h00;
    model_reset();
    repeat (3) @(negedge Clk);
    check_reset_outputs("rst");
    check("rst_wall_x", 32'(wall_x), 32'd0);
    check("rst_wall_y", 32'(wall_y), 32'd0);
    #2 Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge Clk);
    while ((exp_q.size() != 0 || dbg_state != IDLE) && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL frame_timeout: got %0d pending frames expected 0 at %0t", exp_q.size(), $time);
      exp_q.delete();
    end
    check("pending_reqs", 32'(req_q.size()), 32'd0);
    req_q.delete();
  endtask

  task automatic send_frame(input logic [7:0] d, input int lat, input bit extra);
    ack_lat = lat;
    model_frame(d);
    @(negedge Clk);
    frame_tick = 1'b1;
    dir_in = d;
    @(negedge Clk);
    frame_tick = 1'b0;
    dir_in = 8'($urandom);
    if (extra) begin
      frame_tick = 1'b1;
      exp_overrun = 1'b1;
      @(negedge Clk);
      frame_tick = 1'b0;
    end
    wait_done();
  endtask

  task automatic travel(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) send_frame(d, 0, 1'b0);
  endtask

  task automatic reset_mid_handshake();
    int n;
    ack_lat = 40;
    model_frame(8'h16);
    @(negedge Clk);
    frame_tick = 1'b1; dir_in = 8'h16;
    @(negedge Clk);
    frame_tick = 1'b0;
    n = 0;
    while (!wall_req && n < 10) begin
      @(negedge Clk);
      n++;
    end
    check("mid_req_seen", 32'(wall_req), 32'd1);
    #2 Reset_n = 1'b0;
    #1 check_reset_outputs("mid_rst");
    model_reset();
    @(negedge Clk);
    #2 Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    int k;
    logic [7:0] d;
    do_reset();

    send_frame(8'h07, 2, 1'b0);            // new direction, clear: (321,240)
    blocked[321 * 1024 + 239] = 1'b1;
    send_frame(8'h1A, 1, 1'b0);            // up blocked, falls back to right
    blocked.delete();
    send_frame(8'h07, 5, 1'b1);            // second tick while busy
    check("overrun_sticky", 32'(overrun), 32'd1);

    reset_mid_handshake();

    travel(8'h1A, 140);                     // to (320,100)
    travel(8'h04, 312);                     // to (8,100) heading left
    send_frame(8'h00, 1, 1'b0);             // left edge: no request, no move

    travel(8'h16, 140);                     // to (8,240)
    travel(8'h07, 623);                     // to (631,240) heading right
    send_frame(8'h07, 1, 1'b0);             // right edge: no request, no move
    blocked[631 * 1024 + 241] = 1'b1;
    send_frame(8'h16, 2, 1'b0);             // new dir walled, fallback out of bounds
    blocked.delete();

    travel(8'h04, 531);                     // to (100,240)
    travel(8'h16, 231);                     // to (100,471) heading down
    send_frame(8'h16, 1, 1'b0);             // bottom edge: no request, no move

    hash_walls = 1'b1;
    spur_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 4);
      d = (k == 4) ? 8'($urandom) : dir_tab[k];
      send_frame(d, $urandom_range(0, 3), ($urandom_range(0, 11) == 0));
    end
    spur_en = 1'b0;

    repeat (3) @(negedge Clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
